// File: rtl/lfsr22_checker.sv
// lfsr22_checker
//   Receive-side checker for the x^22 + x^21 + 1 PRBS generator. It
//   self-synchronises to the incoming serial stream. Once locked it flywheels
//   a local copy of the sequence and flags every received bit that disagrees
//   with that copy. It also keeps a saturating error count and emits a
//   once-per-period marker.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   in_valid_i   qualifies in_bit_i; all state frozen while low
//   in_bit_i     received PRBS bit
//   clear_cnt_i  synchronous clear of err_count_o (wins over a same-cycle error)
//   locked_o     high while in LOCKED
//   err_o        one-cycle pulse per mismatching valid bit while LOCKED
//   err_count_o  saturating count of LOCKED-state errors
//   cycle_o      one-cycle pulse every PERIOD_LEN locked valid bits
//
// State table
//   SEARCH | filling sr from received bits, counting consecutive correct predictions
//   LOCKED | flywheeling sr from its own predictions, counting/reporting errors

module lfsr22_checker #(
  parameter int LOCK_COUNT  = 32,
  parameter int LOSS_WINDOW = 64,
  parameter int LOSS_ERRS   = 8,
  parameter int ERR_WIDTH   = 32,
  parameter int PERIOD_LEN  = 4194303
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  input  logic                 in_bit_i,
  input  logic                 clear_cnt_i,
  output logic                 locked_o,
  output logic                 err_o,
  output logic [ERR_WIDTH-1:0] err_count_o,
  output logic                 cycle_o
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int WW = $clog2(LOSS_WINDOW);
  localparam int EW = $clog2(LOSS_ERRS + 1);
  localparam int PW = $clog2(PERIOD_LEN);

  localparam logic [4:0]    FILL_FULL = 5'd22;
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(LOSS_WINDOW - 1);
  localparam logic [EW-1:0] LOSS_LAST = EW'(LOSS_ERRS - 1);
  localparam logic [PW-1:0] PER_LAST  = PW'(PERIOD_LEN - 1);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [21:0]          sr_q, sr_d;
  logic [4:0]           fill_q, fill_d;
  logic [MW-1:0]        match_q, match_d;
  logic [WW-1:0]        win_q, win_d;
  logic [EW-1:0]        werr_q, werr_d;
  logic [PW-1:0]        per_q, per_d;
  logic [ERR_WIDTH-1:0] cnt_q, cnt_d;
  logic                 locked_q, locked_d;
  logic                 err_q, err_d;
  logic                 cycle_q, cycle_d;

  logic pred;
  logic mism;
  logic fill_done;
  logic match_ok;
  logic lock_hit;
  logic loss_hit;

  // Prediction is always taken from sr before this cycle's shift.
  assign pred      = sr_q[21] ^ sr_q[20];
  assign mism      = in_valid_i && (in_bit_i != pred);
  assign fill_done = (fill_q == FILL_FULL);
  // An all-zero register predicts zeros forever; never credit it as a match.
  assign match_ok  = in_valid_i && fill_done && (sr_q != '0) && !mism;
  assign lock_hit  = (state_q == SEARCH) && match_ok && (match_q == LOCK_LAST);
  assign loss_hit  = (state_q == LOCKED) && mism && (werr_q == LOSS_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= SEARCH;
      sr_q     <= '0;
      fill_q   <= '0;
      match_q  <= '0;
      win_q    <= '0;
      werr_q   <= '0;
      per_q    <= '0;
      cnt_q    <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      cycle_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      win_q    <= win_d;
      werr_q   <= werr_d;
      per_q    <= per_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      cycle_q  <= cycle_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEARCH:  if (lock_hit) state_d = LOCKED;
      LOCKED:  if (loss_hit) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    sr_d    = sr_q;
    fill_d  = fill_q;
    match_d = match_q;
    win_d   = win_q;
    werr_d  = werr_q;
    per_d   = per_q;
    cnt_d   = cnt_q;

    if (in_valid_i) begin
      if (state_q == SEARCH) begin
        sr_d = {sr_q[20:0], in_bit_i};
        if (!fill_done) begin
          fill_d = fill_q + 5'd1;
        end else if (match_ok) begin
          match_d = match_q + MW'(1);
        end else begin
          match_d = '0;
        end
        if (lock_hit) begin
          match_d = '0;
          win_d   = '0;
          werr_d  = '0;
          per_d   = '0;
        end
      end else begin
        sr_d  = {sr_q[20:0], pred};
        per_d = (per_q == PER_LAST) ? '0 : per_q + PW'(1);
        // The current bit's error belongs to the window it lands in, so the
        // loss test above sees it before the tally restarts.
        if (win_q == WIN_LAST) begin
          win_d  = '0;
          werr_d = '0;
        end else begin
          win_d  = win_q + WW'(1);
          werr_d = werr_q + EW'(mism);
        end
        if (loss_hit) begin
          fill_d  = '0;
          match_d = '0;
        end
      end
    end

    if (clear_cnt_i) begin
      cnt_d = '0;
    end else if ((state_q == LOCKED) && mism && (cnt_q != '1)) begin
      cnt_d = cnt_q + ERR_WIDTH'(1);
    end
  end

  always_comb begin
    locked_d = (state_d == LOCKED);
    err_d    = (state_q == LOCKED) && mism;
    cycle_d  = (state_q == LOCKED) && in_valid_i && (per_q == PER_LAST);
  end

  assign locked_o    = locked_q;
  assign err_o       = err_q;
  assign err_count_o = cnt_q;
  assign cycle_o     = cycle_q;

endmodule
